// File: rtl/rca_operand_sequencer_pkg.sv
// rca_operand_sequencer_pkg
//   Constants and types shared by the operand sequencer, its settle timer and
//   its bus interface.
//   RCA_NBIT      : default operand/sum width; it must match decomposed_rca.
//   SETTLE_CNT_W  : settle counter width, which sets SETTLE_CYCLES to at most 15.
//   seq_state_t   : sequencer FSM encoding (IDLE=0, SETTLE=1, HOLD=2).
//   settle_cfg_ok : legality check for the SETTLE_CYCLES parameter.
package rca_operand_sequencer_pkg;

    localparam int RCA_NBIT     = 16;
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_t;

    function automatic bit settle_cfg_ok(input int n);
        return (n >= 1) && (n <= (1 << SETTLE_CNT_W) - 1);
    endfunction

endpackage

// File: rtl/rca_operand_sequencer_if.sv
// rca_operand_sequencer_if
//   Bundles the operand handshake, the adder drive/return and the result
//   handshake of the operand sequencer.
//   Parameter NBIT : operand/sum width.
//   Signals:
//     in_valid, in_ready, in_a, in_b : operand pair handshake.
//     add_a, add_b, add_s            : drive to and sum from decomposed_rca.
//     out_valid, out_ready, out_s    : captured-sum handshake.
//     busy                           : sequencer is in SETTLE or HOLD.
//     out_carry                      : unsigned carry-out, present only when
//                                      RCA_SEQ_OVERFLOW_EN is defined.
//   Modports:
//     slave  : the sequencer side.
//     master : the environment (producer, consumer and adder).
interface rca_operand_sequencer_if
    import rca_operand_sequencer_pkg::*;
#(
    parameter int NBIT = RCA_NBIT
);
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] in_a;
    logic [NBIT-1:0] in_b;
    logic [NBIT-1:0] add_a;
    logic [NBIT-1:0] add_b;
    logic [NBIT-1:0] add_s;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] out_s;
    logic            busy;
`ifdef RCA_SEQ_OVERFLOW_EN
    logic            out_carry;
`endif

    modport slave (
        input  in_valid, in_a, in_b, out_ready, add_s,
        output in_ready, add_a, add_b, out_valid, out_s, busy
`ifdef RCA_SEQ_OVERFLOW_EN
        , output out_carry
`endif
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, add_s,
        input  in_ready, add_a, add_b, out_valid, out_s, busy
`ifdef RCA_SEQ_OVERFLOW_EN
        , input out_carry
`endif
    );

endinterface

// File: rtl/rca_settle_timer.sv
// rca_settle_timer
//   Load/decrement down-counter that times the ripple-carry settle window.
//   The counter is loaded when a pair is launched and steps down once per
//   clock until it reaches zero.
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous active-high reset, clears the count to 0
//     load       : load load_value; this takes priority over dec
//     dec        : decrement; the count saturates at zero
//     load_value : value to load
//     zero       : count is zero
module rca_settle_timer
    import rca_operand_sequencer_pkg::*;
#(
    parameter int CNT_W = SETTLE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_value;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/rca_operand_sequencer.sv
// rca_operand_sequencer
//   Upstream driver and result capturer for the combinational decomposed_rca
//   adder. The block accepts an operand pair and registers it onto the adder
//   inputs. It waits SETTLE_CYCLES clocks for the ripple carry to resolve. It
//   then captures the sum and presents it on a valid/ready output. The multi-
//   cycle ripple path becomes a timed stage that can take back-pressure.
//   Parameters:
//     NBIT          : operand/sum width (must match decomposed_rca)
//     SETTLE_CYCLES : clocks from operand launch to sum capture, 1..15
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : rca_operand_sequencer_if.slave (operand/result handshakes, adder
//           A/B drive and S return, busy)
//   Optional feature macro RCA_SEQ_OVERFLOW_EN: adds bus.out_carry. It is
//   captured together with out_s as the unsigned carry-out (add_s < add_a).
module rca_operand_sequencer
    import rca_operand_sequencer_pkg::*;
#(
    parameter int NBIT          = RCA_NBIT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    rca_operand_sequencer_if.slave bus
);

    // An illegal settle count is reported at elaboration, before any clock.
    if (!settle_cfg_ok(SETTLE_CYCLES)) begin : g_bad_settle_cfg
        $error("rca_operand_sequencer: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
    end

    // The counter counts down to zero inclusive, so it loads one less than the window.
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t      state_reg;
    seq_state_t      state_next;

    logic [NBIT-1:0] add_a_reg;
    logic [NBIT-1:0] add_b_reg;
    logic [NBIT-1:0] out_s_reg;
    logic            out_valid_reg;

    logic            in_ready_int;
    logic            busy_int;
    logic            capture;
    logic            timer_dec;
    logic            timer_zero;
    logic            accept;
    logic            hand_off;

    rca_settle_timer #(
        .CNT_W (SETTLE_CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .dec        (timer_dec),
        .load_value (SETTLE_LOAD),
        .zero       (timer_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_next = bus.in_valid ? ST_SETTLE : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs. In HOLD, in_ready follows out_ready. The next pair can
    // therefore launch on the same edge that retires the current sum.
    always_comb begin
        in_ready_int = 1'b0;
        busy_int     = 1'b0;
        capture      = 1'b0;
        timer_dec    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                in_ready_int = 1'b1;
            end
            ST_SETTLE: begin
                busy_int = 1'b1;
                if (timer_zero) begin
                    capture = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                busy_int     = 1'b1;
                in_ready_int = bus.out_ready;
            end
            default: ;
        endcase
        if (rst) begin
            in_ready_int = 1'b0;
        end
    end

    assign accept   = bus.in_valid && in_ready_int;
    assign hand_off = (state_reg == ST_HOLD) && bus.out_ready;

    // The operand registers change only on an accept edge. They stay stable
    // through capture, so add_s is read on a settled path.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a_reg <= '0;
            add_b_reg <= '0;
        end else if (accept) begin
            add_a_reg <= bus.in_a;
            add_b_reg <= bus.in_b;
        end
    end

    // The result register keeps its value after the handshake until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_s_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else if (capture) begin
            out_s_reg     <= bus.add_s;
            out_valid_reg <= 1'b1;
        end else if (hand_off) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef RCA_SEQ_OVERFLOW_EN
    logic out_carry_reg;

    // The sum wraps exactly when it is smaller than either unsigned operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_carry_reg <= 1'b0;
        end else if (capture) begin
            out_carry_reg <= (bus.add_s < add_a_reg);
        end
    end

    assign bus.out_carry = out_carry_reg;
`endif

    assign bus.in_ready  = in_ready_int;
    assign bus.busy      = busy_int;
    assign bus.add_a     = add_a_reg;
    assign bus.add_b     = add_b_reg;
    assign bus.out_s     = out_s_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_rca_operand_sequencer.sv
// tb_rca_operand_sequencer
//   Bench for rca_operand_sequencer. There are two instances: dut1 has
//   SETTLE_CYCLES=2 and dut2 has SETTLE_CYCLES=1. Each instance drives a
//   behavioural NBIT-bit adder that stands in for decomposed_rca. Expected
//   sums are queued when a pair is driven. A monitor pops and compares them
//   when a result handshake is seen. Define RCA_SEQ_OVERFLOW_EN to check
//   out_carry as well.
module tb_rca_operand_sequencer;
    import rca_operand_sequencer_pkg::*;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    rca_operand_sequencer_if #(.NBIT(16)) bus1 ();
    rca_operand_sequencer_if #(.NBIT(16)) bus2 ();

    rca_operand_sequencer #(.NBIT(16), .SETTLE_CYCLES(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    rca_operand_sequencer #(.NBIT(16), .SETTLE_CYCLES(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Stand-ins for the decomposed_rca sum outputs.
    assign bus1.add_s = bus1.add_a + bus1.add_b;
    assign bus2.add_s = bus2.add_a + bus2.add_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out1(input int max_cyc, output int n);
        n = 0;
        while (!bus1.out_valid && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    // Launch one pair on dut1 with out_ready=1 and retire its result.
    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] s, input logic c, input string tag);
        int n;
        bus1.in_valid = 1'b1;
        bus1.in_a     = a;
        bus1.in_b     = b;
        q1.push_back('{s: s, c: c});
        tick();
        bus1.in_valid = 1'b0;
        wait_out1(10, n);
        check({tag, "_latency"}, n, 2);
        tick();
        check({tag, "_retired"}, bus1.out_valid, 1'b0);
    endtask

    // Scoreboard monitors. At the negedge, valid && ready marks a transfer
    // on the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
            total++;
            assert (q1.size() != 0)
            else begin
                bad++;
                $error("FAIL sb1_unexpected: observed out_s=%0h expected no result", bus1.out_s);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                $display("dut1 result out_s=%0d", bus1.out_s);
                check("sb1_out_s", bus1.out_s, e.s);
`ifdef RCA_SEQ_OVERFLOW_EN
                check("sb1_out_carry", bus1.out_carry, e.c);
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
            total++;
            assert (q2.size() != 0)
            else begin
                bad++;
                $error("FAIL sb2_unexpected: observed out_s=%0h expected no result", bus2.out_s);
            end
            if (q2.size() != 0) begin
                e = q2.pop_front();
                $display("dut2 result out_s=%0d", bus2.out_s);
                check("sb2_out_s", bus2.out_s, e.s);
`ifdef RCA_SEQ_OVERFLOW_EN
                check("sb2_out_carry", bus2.out_carry, e.c);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        // Check the outputs while reset is held.
        check("rst_in_ready", bus1.in_ready, 1'b0);
        check("rst_out_valid", bus1.out_valid, 1'b0);
        check("rst_add_a", bus1.add_a, 16'd0);
        check("rst_out_s", bus1.out_s, 16'd0);
        check("rst_busy", bus1.busy, 1'b0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", bus1.in_ready, 1'b1);

        // 1. Basic add.
        bus1.in_valid = 1'b1; bus1.in_a = 16'd2; bus1.in_b = 16'd3;
        q1.push_back('{s: 16'd5, c: 1'b0});
        tick();
        bus1.in_valid = 1'b0;
        check("t1_in_ready_settle", bus1.in_ready, 1'b0);
        check("t1_busy", bus1.busy, 1'b1);
        check("t1_add_a", bus1.add_a, 16'd2);
        check("t1_add_b", bus1.add_b, 16'd3);
        wait_out1(10, n);
        check("t1_latency", n, 2);
        check("t1_add_a_held", bus1.add_a, 16'd2);
        tick();
        check("t1_retired", bus1.out_valid, 1'b0);
        check("t1_idle", bus1.busy, 1'b0);

        // 2. Back-to-back, in_valid held high.
        bus1.in_valid = 1'b1; bus1.in_a = 16'd77; bus1.in_b = 16'd118;
        q1.push_back('{s: 16'd195, c: 1'b0});
        tick();
        bus1.in_a = 16'd17; bus1.in_b = 16'd58;
        q1.push_back('{s: 16'd75, c: 1'b0});
        wait_out1(10, n);
        check("t2_first_latency", n, 2);
        check("t2_in_ready_hold", bus1.in_ready, 1'b1);
        tick();
        bus1.in_valid = 1'b0;
        check("t2_valid_fell", bus1.out_valid, 1'b0);
        check("t2_relaunch_busy", bus1.busy, 1'b1);
        check("t2_relaunch_add_a", bus1.add_a, 16'd17);
        wait_out1(10, n);
        check("t2_second_gap", n + 1, 3);
        tick();
        check("t2_idle", bus1.busy, 1'b0);

        // 3. Back-pressure.
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_a = 16'd7; bus1.in_b = 16'd8;
        q1.push_back('{s: 16'd15, c: 1'b0});
        tick();
        bus1.in_valid = 1'b0;
        wait_out1(10, n);
        check("t3_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", bus1.out_valid, 1'b1);
            check("t3_hold_out_s", bus1.out_s, 16'd15);
            check("t3_hold_in_ready", bus1.in_ready, 1'b0);
            check("t3_hold_add_a", bus1.add_a, 16'd7);
            tick();
        end
        bus1.out_ready = 1'b1;
        #1;
        check("t3_release_in_ready", bus1.in_ready, 1'b1);
        tick();
        check("t3_retired", bus1.out_valid, 1'b0);
        check("t3_idle", bus1.busy, 1'b0);

        // 4. Wrap, then a sum without a carry.
        run_one(16'hFFFF, 16'h0002, 16'h0001, 1'b1, "t4_wrap");
        run_one(16'd118, 16'd339, 16'd457, 1'b0, "t4_nowrap");

        // 5. Reset one edge after the accept.
        bus1.in_valid = 1'b1; bus1.in_a = 16'd2; bus1.in_b = 16'd3;
        tick();
        bus1.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_out_valid", bus1.out_valid, 1'b0);
        check("t5_add_a", bus1.add_a, 16'd0);
        check("t5_add_b", bus1.add_b, 16'd0);
        check("t5_out_s", bus1.out_s, 16'd0);
        check("t5_busy", bus1.busy, 1'b0);
        check("t5_in_ready_in_rst", bus1.in_ready, 1'b0);
`ifdef RCA_SEQ_OVERFLOW_EN
        check("t5_out_carry", bus1.out_carry, 1'b0);
`endif
        rst = 1'b0;
        #1;
        check("t5_in_ready_after", bus1.in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_valid", bus1.out_valid, 1'b0);
        end

        // 6. SETTLE_CYCLES=1 instance, back-to-back.
        bus2.in_valid = 1'b1; bus2.in_a = 16'd0; bus2.in_b = 16'd0;
        q2.push_back('{s: 16'd0, c: 1'b0});
        tick();
        bus2.in_a = 16'd2; bus2.in_b = 16'd3;
        q2.push_back('{s: 16'd5, c: 1'b0});
        check("t6_settle_no_valid", bus2.out_valid, 1'b0);
        tick();
        check("t6_first_valid", bus2.out_valid, 1'b1);
        tick();
        bus2.in_valid = 1'b0;
        check("t6_relaunch", bus2.out_valid, 1'b0);
        tick();
        check("t6_second_valid", bus2.out_valid, 1'b1);
        tick();
        check("t6_retired", bus2.out_valid, 1'b0);

        tick();
        tick();
        check("sb1_drained", q1.size(), 0);
        check("sb2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
